// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, constants and ALU op encoding for the single-bus datapath.
package datapath_pkg;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] ZERO_WORD = '0;
   typedef enum logic [1:0] {OP_PASS = 2'd0, OP_INC = 2'd1, OP_AND = 2'd2} alu_op_e;
endpackage

// File: rtl/reg32.sv
// reg32: 32-bit register with load enable and asynchronous active-low clear.
module reg32
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= ZERO_WORD;
      else if (en) q <= d;
endmodule

// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath; strobes from an external control unit
// move values between PC, IR, Y, Z, MAR, MDR and R2/R4/R5 through one shared bus.
module datapath
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCout,
   input  logic              Zlowout,
   input  logic              MDRout,
   input  logic              R2out,
   input  logic              R4out,
   input  logic              MARin,
   input  logic              Zin,
   input  logic              PCin,
   input  logic              MDRin,
   input  logic              IRin,
   input  logic              Yin,
   input  logic              R2in,
   input  logic              R4in,
   input  logic              R5in,
   input  logic              read,
   input  logic              IncPC,
   input  logic              AND,
   input  logic [WORD_W-1:0] Mdatain,
   output logic [WORD_W-1:0] BusMuxOut,
   output logic [WORD_W-1:0] IR_q,
   output logic [WORD_W-1:0] MAR_q
);
   logic [WORD_W-1:0] bus, pc_q, ir_q, y_q, mar_q, mdr_q, r2_q, r4_q, r5_q, mdr_d, alu_lo;
   logic [2*WORD_W-1:0] z_q;
   alu_op_e alu_op;
   logic unused_ok;
   always_comb begin
      bus = Zlowout ? z_q[WORD_W-1:0] : MDRout ? mdr_q : PCout ? pc_q :
            R2out ? r2_q : R4out ? r4_q : ZERO_WORD;
      alu_op = IncPC ? OP_INC : AND ? OP_AND : OP_PASS;
      alu_lo = (alu_op == OP_INC) ? bus + 32'd1 : (alu_op == OP_AND) ? (y_q & bus) : bus;
      mdr_d = read ? Mdatain : bus;
   end
   // Upper half of Z is reserved for a future multiply/divide result.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) z_q <= '0;
      else if (Zin) z_q <= {ZERO_WORD, alu_lo};
   reg32 u_pc  (.clk(clk), .rst_n(rst_n), .en(PCin),  .d(bus),   .q(pc_q));
   reg32 u_ir  (.clk(clk), .rst_n(rst_n), .en(IRin),  .d(bus),   .q(ir_q));
   reg32 u_y   (.clk(clk), .rst_n(rst_n), .en(Yin),   .d(bus),   .q(y_q));
   reg32 u_mar (.clk(clk), .rst_n(rst_n), .en(MARin), .d(bus),   .q(mar_q));
   reg32 u_mdr (.clk(clk), .rst_n(rst_n), .en(MDRin), .d(mdr_d), .q(mdr_q));
   reg32 u_r2  (.clk(clk), .rst_n(rst_n), .en(R2in),  .d(bus),   .q(r2_q));
   reg32 u_r4  (.clk(clk), .rst_n(rst_n), .en(R4in),  .d(bus),   .q(r4_q));
   reg32 u_r5  (.clk(clk), .rst_n(rst_n), .en(R5in),  .d(bus),   .q(r5_q));
   assign unused_ok = ^{z_q[2*WORD_W-1:WORD_W], r5_q};
   assign BusMuxOut = bus;
   assign IR_q = ir_q;
   assign MAR_q = mar_q;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: table-driven vectors, reset/pulse corner sequences and random
// strobes checked against a register-transfer reference model.
module tb_datapath;
   localparam logic [16:0] C_PCOUT = 17'd1, C_ZLOUT = 17'd2, C_MDROUT = 17'd4,
      C_R2OUT = 17'd8, C_R4OUT = 17'd16, C_MARIN = 17'd32, C_ZIN = 17'd64,
      C_PCIN = 17'd128, C_MDRIN = 17'd256, C_IRIN = 17'd512, C_YIN = 17'd1024,
      C_R2IN = 17'd2048, C_R4IN = 17'd4096, C_R5IN = 17'd8192, C_READ = 17'd16384,
      C_INC = 17'd32768, C_AND = 17'd65536;
   localparam int K_NONE = 0, K_BUS = 1, K_PC = 2, K_IR = 3, K_Y = 4, K_ZLO = 5,
      K_ZHI = 6, K_MAR = 7, K_MDR = 8, K_R2 = 9, K_R4 = 10, K_R5 = 11;
   typedef struct {
      logic [16:0] c;
      logic [31:0] md;
      int k1;
      logic [31:0] e1;
      int k2;
      logic [31:0] e2;
   } vec_t;
   logic clk = 0, rst_n = 1;
   logic [16:0] ctrl = '0;
   logic [31:0] md = '0, bus_o, ir_o, mar_o;
   int tests = 0, fails = 0;
   string kname [12] = '{"none", "bus", "pc", "ir", "y", "z_lo", "z_hi", "mar", "mdr", "r2", "r4", "r5"};
   vec_t tbl[$];
   always #5 clk = ~clk;
   datapath dut (
      .clk(clk), .rst_n(rst_n),
      .PCout(ctrl[0]), .Zlowout(ctrl[1]), .MDRout(ctrl[2]), .R2out(ctrl[3]), .R4out(ctrl[4]),
      .MARin(ctrl[5]), .Zin(ctrl[6]), .PCin(ctrl[7]), .MDRin(ctrl[8]), .IRin(ctrl[9]),
      .Yin(ctrl[10]), .R2in(ctrl[11]), .R4in(ctrl[12]), .R5in(ctrl[13]), .read(ctrl[14]),
      .IncPC(ctrl[15]), .AND(ctrl[16]), .Mdatain(md),
      .BusMuxOut(bus_o), .IR_q(ir_o), .MAR_q(mar_o)
   );
   function automatic logic [31:0] obs(int k);
      case (k)
         K_BUS: return bus_o;
         K_PC:  return dut.pc_q;
         K_IR:  return ir_o;
         K_Y:   return dut.y_q;
         K_ZLO: return dut.z_q[31:0];
         K_ZHI: return dut.z_q[63:32];
         K_MAR: return mar_o;
         K_MDR: return dut.mdr_q;
         K_R2:  return dut.r2_q;
         K_R4:  return dut.r4_q;
         K_R5:  return dut.r5_q;
         default: return 32'h0;
      endcase
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(logic [16:0] c, logic [31:0] m, int k1, logic [31:0] e1,
                               int k2 = K_NONE, logic [31:0] e2 = 0);
      vec_t v;
      v.c = c; v.md = m; v.k1 = k1; v.e1 = e1; v.k2 = k2; v.e2 = e2;
      return v;
   endfunction
   // Reference model: plain register-transfer semantics on named registers.
   logic [31:0] m_pc, m_ir, m_y, m_mar, m_mdr, m_r2, m_r4, m_r5;
   logic [63:0] m_z;
   function automatic logic [31:0] m_bus(logic [16:0] c);
      if (c[1]) return m_z[31:0];
      if (c[2]) return m_mdr;
      if (c[0]) return m_pc;
      if (c[3]) return m_r2;
      if (c[4]) return m_r4;
      return 32'h0;
   endfunction
   task automatic m_step(logic [16:0] c, logic [31:0] m);
      logic [31:0] b, a;
      b = m_bus(c);
      a = c[15] ? b + 1 : c[16] ? (m_y & b) : b;
      if (c[6]) m_z = {32'h0, a};
      if (c[7]) m_pc = b;
      if (c[8]) m_mdr = c[14] ? m : b;
      if (c[9]) m_ir = b;
      if (c[10]) m_y = b;
      if (c[5]) m_mar = b;
      if (c[11]) m_r2 = b;
      if (c[12]) m_r4 = b;
      if (c[13]) m_r5 = b;
   endtask
   initial begin
      #2 rst_n = 0;
      #1;
      for (int k = K_BUS; k <= K_R5; k++) chk({"reset_", kname[k]}, obs(k), 32'h0);
      @(negedge clk) rst_n = 1;
      tbl.push_back(mk(C_READ | C_MDRIN, 32'h22, K_MDR, 32'h22));
      tbl.push_back(mk(C_MDROUT | C_R2IN, 0, K_R2, 32'h22));
      tbl.push_back(mk(C_READ | C_MDRIN, 32'h24, K_MDR, 32'h24));
      tbl.push_back(mk(C_MDROUT | C_R4IN, 0, K_R4, 32'h24));
      tbl.push_back(mk(C_READ | C_MDRIN, 32'h26, K_MDR, 32'h26));
      tbl.push_back(mk(C_MDROUT | C_R5IN, 0, K_R5, 32'h26));
      tbl.push_back(mk(C_PCOUT | C_MARIN | C_INC | C_ZIN, 0, K_MAR, 32'h0, K_ZLO, 32'h1));
      tbl.push_back(mk(C_ZLOUT | C_PCIN | C_READ | C_MDRIN, 32'h4A920000, K_PC, 32'h1, K_MDR, 32'h4A920000));
      tbl.push_back(mk(C_MDROUT | C_IRIN, 0, K_IR, 32'h4A920000, K_MAR, 32'h0));
      tbl.push_back(mk(C_R2OUT | C_YIN, 0, K_Y, 32'h22, K_BUS, 32'h22));
      tbl.push_back(mk(C_R4OUT | C_AND | C_ZIN, 0, K_ZLO, 32'h20, K_ZHI, 32'h0));
      tbl.push_back(mk(C_ZLOUT | C_R5IN, 0, K_R5, 32'h20, K_BUS, 32'h20));
      tbl.push_back(mk(C_ZLOUT | C_R2OUT, 0, K_BUS, 32'h20));
      tbl.push_back(mk(C_MDROUT | C_PCOUT, 0, K_BUS, 32'h4A920000));
      tbl.push_back(mk(C_PCOUT | C_R2OUT, 0, K_BUS, 32'h1));
      tbl.push_back(mk(C_R2OUT | C_R4OUT, 0, K_BUS, 32'h22));
      tbl.push_back(mk(17'd0, 0, K_BUS, 32'h0));
      tbl.push_back(mk(C_R2OUT | C_ZIN, 0, K_ZLO, 32'h22));
      tbl.push_back(mk(C_READ | C_MDRIN, 32'hFFFFFFFF, K_MDR, 32'hFFFFFFFF));
      tbl.push_back(mk(C_MDROUT | C_PCIN, 0, K_PC, 32'hFFFFFFFF));
      tbl.push_back(mk(C_PCOUT | C_INC | C_AND | C_ZIN, 0, K_ZLO, 32'h0, K_ZHI, 32'h0));
      tbl.push_back(mk(17'd0, 32'h12345678, K_R2, 32'h22, K_R4, 32'h24));
      tbl.push_back(mk(17'd0, 32'h12345678, K_R5, 32'h20, K_Y, 32'h22));
      tbl.push_back(mk(17'd0, 32'h12345678, K_PC, 32'hFFFFFFFF, K_IR, 32'h4A920000));
      tbl.push_back(mk(C_R4OUT | C_MDRIN, 32'hDEADBEEF, K_MDR, 32'h24));
      tbl.push_back(mk(C_PCOUT | C_PCIN | C_INC | C_ZIN, 0, K_PC, 32'hFFFFFFFF, K_ZLO, 32'h0));
      foreach (tbl[i]) begin
         @(negedge clk);
         ctrl = tbl[i].c;
         md = tbl[i].md;
         #1;
         if (tbl[i].k1 == K_BUS) chk($sformatf("v%0d_%s", i, kname[K_BUS]), obs(K_BUS), tbl[i].e1);
         if (tbl[i].k2 == K_BUS) chk($sformatf("v%0d_%s", i, kname[K_BUS]), obs(K_BUS), tbl[i].e2);
         @(posedge clk);
         #1;
         if (tbl[i].k1 > K_BUS) chk($sformatf("v%0d_%s", i, kname[tbl[i].k1]), obs(tbl[i].k1), tbl[i].e1);
         if (tbl[i].k2 > K_BUS) chk($sformatf("v%0d_%s", i, kname[tbl[i].k2]), obs(tbl[i].k2), tbl[i].e2);
      end
      // Mid-sequence asynchronous reset, checked before any clock edge.
      @(negedge clk);
      ctrl = C_ZLOUT;
      #2 rst_n = 0;
      #1;
      for (int k = K_BUS; k <= K_R5; k++) chk({"midreset_", kname[k]}, obs(k), 32'h0);
      #1 rst_n = 1;
      @(negedge clk);
      ctrl = C_READ | C_MDRIN;
      md = 32'h5A;
      @(posedge clk);
      #1 chk("resume_mdr", obs(K_MDR), 32'h5A);
      // Strobe pulse that never spans a rising edge.
      @(negedge clk);
      md = 32'h77;
      #1 ctrl = C_READ | C_MDRIN | C_R2IN;
      #2 ctrl = '0;
      @(posedge clk);
      #1 chk("pulse_mdr", obs(K_MDR), 32'h5A);
      chk("pulse_r2", obs(K_R2), 32'h0);
      // Random strobes against the model, starting from a fresh reset.
      @(negedge clk);
      ctrl = '0;
      rst_n = 0;
      {m_pc, m_ir, m_y, m_mar, m_mdr, m_r2, m_r4, m_r5} = '0;
      m_z = '0;
      #1 rst_n = 1;
      for (int n = 0; n < 300; n++) begin
         logic [16:0] c;
         @(negedge clk);
         c = 17'($urandom);
         if ($urandom_range(1, 0) == 1) c[4:0] = 5'(1 << $urandom_range(4, 0));
         ctrl = c;
         md = ($urandom_range(7, 0) == 0) ? 32'hFFFFFFFF : $urandom;
         #1 chk($sformatf("rnd%0d_bus", n), obs(K_BUS), m_bus(c));
         m_step(c, md);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d_pc", n), obs(K_PC), m_pc);
         chk($sformatf("rnd%0d_ir", n), obs(K_IR), m_ir);
         chk($sformatf("rnd%0d_y", n), obs(K_Y), m_y);
         chk($sformatf("rnd%0d_zlo", n), obs(K_ZLO), m_z[31:0]);
         chk($sformatf("rnd%0d_zhi", n), obs(K_ZHI), m_z[63:32]);
         chk($sformatf("rnd%0d_mar", n), obs(K_MAR), m_mar);
         chk($sformatf("rnd%0d_mdr", n), obs(K_MDR), m_mdr);
         chk($sformatf("rnd%0d_r2", n), obs(K_R2), m_r2);
         chk($sformatf("rnd%0d_r4", n), obs(K_R4), m_r4);
         chk($sformatf("rnd%0d_r5", n), obs(K_R5), m_r5);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
